// File: rtl/demux_4_pkg.sv
// Shared constants and FSM state type for the 1:4 packet demultiplexer.
package demux_4_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_e;

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output register for a single demux channel.
// A new beat may be loaded in the same cycle the held beat drains,
// giving one beat per cycle of throughput.
module demux_chan_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    input  logic              d_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] q,
    output logic              q_last,
    output logic              can_load
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    // Load has priority over drain; data and last hold while stalled or after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= d;
            last_q  <= d_last;
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid    = valid_q;
    assign q        = data_q;
    assign q_last   = last_q;
    assign can_load = !valid_q || ready;

endmodule

// File: rtl/demux_4_stream.sv
// 1:4 packet demultiplexer. The select is captured on the head beat and
// held for the rest of the packet; each channel has its own output register.
module demux_4_stream
    import demux_4_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    input  logic [SEL_W-1:0]         s_sel,
    output logic                     s_ready,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    output logic [NUM_CH-1:0]        m_valid,
    output logic [NUM_CH-1:0]        m_last,
    input  logic [NUM_CH-1:0]        m_ready,
    output logic                     busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   lock_sel_q, lock_sel_d;
    logic [SEL_W-1:0]   eff;
    logic               accept;
    logic [NUM_CH-1:0]  load;
    logic [NUM_CH-1:0]  can_load;

    // Channel decode, ready/accept, per-channel load strobes and packet FSM next state.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        eff        = (state_q == ST_IN_PKT) ? lock_sel_q : s_sel;
        s_ready    = can_load[eff];
        accept     = s_valid && s_ready;
        load       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            load[k] = accept && (eff == SEL_W'(k));
        end
        case (state_q)
            ST_IDLE: begin
                if (accept && !s_last) begin
                    state_d    = ST_IN_PKT;
                    lock_sel_d = s_sel;
                end
            end
            ST_IN_PKT: begin
                if (accept && s_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and locked select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    assign busy = (state_q == ST_IN_PKT);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        demux_chan_reg #(
            .DATA_W (DATA_W)
        ) u_reg (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[i]),
            .d        (s_data),
            .d_last   (s_last),
            .ready    (m_ready[i]),
            .valid    (m_valid[i]),
            .q        (m_data[i*DATA_W +: DATA_W]),
            .q_last   (m_last[i]),
            .can_load (can_load[i])
        );
    end

endmodule

// File: doc/demux_4_stream.md
Name: demux_4_stream

Overview:
- 1:4 packet demultiplexer: one valid/ready input stream is routed to one of four output channels chosen by a 2-bit select.
- The select is sampled on the first beat of each packet and held until the last beat, so packets are never split.
- Each channel has its own one-entry output register, so a stalled channel does not block traffic to the others.
- It is the receive-side fan-out that pairs with the team's 4:1 mux selection logic.

Parameters:
- DATA_W, 8, width of the data beat.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- s_data  input  DATA_W  input beat.
- s_valid  input  1  input beat present.
- s_last  input  1  input beat is the last of its packet.
- s_sel  input  2  destination channel; sampled only on the first beat of a packet.
- s_ready  output  1  input beat accepted this cycle when s_valid is also high.
- m_data  output  4*DATA_W  channel i data occupies bits [i*DATA_W +: DATA_W].
- m_valid  output  4  per-channel beat present.
- m_last  output  4  per-channel last flag.
- m_ready  input  4  per-channel downstream ready.
- busy  output  1  high while a multi-beat packet is open (state IN_PKT).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, lock_sel=0, m_valid=0, m_last=0, m_data=0, busy=0.
  - Reset mid-packet discards the partial packet and all held beats.
  - The first accepted beat after reset is treated as a packet head.
- Effective channel: eff = s_sel in IDLE, lock_sel in IN_PKT. s_sel is ignored in IN_PKT.
- s_ready = !m_valid[eff] || m_ready[eff].
  - Combinational from m_ready and s_sel.
  - s_ready must not depend on s_valid.
- accept = s_valid && s_ready.
- FSM:
  - IDLE, accept, !s_last -> IN_PKT; lock_sel <= s_sel.
  - IDLE, accept, s_last -> IDLE (single-beat packet).
  - IN_PKT, accept, s_last -> IN_PKT exits to IDLE.
  - All other cases hold state.
  - busy = (state==IN_PKT).
- Channel register i, evaluated each cycle:
  - accept && eff==i: load data and last; m_valid[i] <= 1. This applies even if the current beat drains in the same cycle, giving full throughput of one beat per cycle.
  - else if m_valid[i] && m_ready[i]: m_valid[i] <= 0.
  - Otherwise hold. m_data and m_last remain stable while m_valid[i] && !m_ready[i].
- Latency: accepted beat appears on m_valid[eff] the next cycle.
- Other channels drain independently in any cycle.
- m_ready[i] while m_valid[i]=0 has no effect.
- m_data[i] keeps its last loaded value after draining (no clearing).
- s_valid low in the middle of a packet keeps the state and the lock.
- No ordering is guaranteed across channels; ordering within a channel is preserved.

Decomposition:
- Package demux_4_pkg:
  - NUM_CH=4, SEL_W=2.
  - State encodings ST_IDLE=1'b0, ST_IN_PKT=1'b1.
- Sub-module demux_chan_reg (params DATA_W):
  - Holds a one-entry register.
  - Ports: clk, rst_n, load, d, d_last, ready, valid, q, q_last, can_load.
  - Instantiated 4x from a generate loop.
- Top level contains only the FSM, lock_sel, and the eff / s_ready decode.

Test Plan:
- Reset then idle: all m_ready=1, 3-beat packet s_sel=2, data 0x11,0x22,0x33, last on beat 3.
  - m_valid=4'b0100 on cycles 1-3 after each accept, data 0x11,0x22,0x33.
  - m_last[2] on 0x33 only.
  - busy high from after beat 1 until after beat 3.
- Select lock: during the 3-beat packet, drive s_sel 0, then 3, then 1 on beats 2 and 3.
  - All beats still appear only on channel 2; lock_sel unaffected.
- Back-pressure: m_ready[1]=0, single-beat 0xA5 to ch1, then a second beat to ch1.
  - m_valid[1]=1 holding 0xA5; s_ready=0 for the second beat.
  - Raise m_ready[1]: the second beat is accepted that cycle and appears next cycle.
- Non-blocking: ch1 stalled full with 0xA5; send a single beat 0x5A with s_sel=3.
  - s_ready=1; m_valid=4'b1010 next cycle; ch1 still holds 0xA5.
- Full throughput: all m_ready=1; 8 back-to-back single-beat packets, sel 0,1,2,3,0,1,2,3.
  - s_ready stays 1 throughout; 8 beats out in 8 consecutive cycles, one per cycle in order.
- Async reset mid-packet: assert rst_n low between clock edges after beat 2 of 4.
  - m_valid=0 and busy=0 immediately, without waiting for an edge.
  - After release, the next beat with s_sel=0 goes to ch0.
